// File: rtl/if_id_stage.sv
// Elastic IF/ID stage: valid/ready handshake carrying PC and instruction from fetch to decode.
// Define IF_ID_SKID_EN to add a second (skid) entry so in_ready comes straight from a flop.
module if_id_stage #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [1:0]        occupancy
);

  logic              main_valid, main_valid_nxt;
  logic [PC_W-1:0]   main_pc, main_pc_nxt;
  logic [INST_W-1:0] main_inst, main_inst_nxt;
  logic [1:0]        occ_q;
  logic              in_xfer, out_xfer, main_free;

  assign out_xfer  = main_valid & out_ready;
  assign in_xfer   = in_valid & in_ready;
  assign main_free = ~main_valid | out_xfer;

`ifdef IF_ID_SKID_EN
  logic              skid_valid, skid_valid_nxt;
  logic [PC_W-1:0]   skid_pc, skid_pc_nxt;
  logic [INST_W-1:0] skid_inst, skid_inst_nxt;
  logic              ready_q;

  assign in_ready = ready_q;

  always_comb begin
    main_valid_nxt = main_valid;
    main_pc_nxt    = main_pc;
    main_inst_nxt  = main_inst;
    skid_valid_nxt = skid_valid;
    skid_pc_nxt    = skid_pc;
    skid_inst_nxt  = skid_inst;
    if (rst || flush) begin
      main_valid_nxt = 1'b0;
      skid_valid_nxt = 1'b0;
    end else begin
      if (main_free) begin
        // the skid entry is always older than anything arriving now
        if (skid_valid) begin
          main_valid_nxt = 1'b1;
          main_pc_nxt    = skid_pc;
          main_inst_nxt  = skid_inst;
          skid_valid_nxt = 1'b0;
        end else if (in_xfer) begin
          main_valid_nxt = 1'b1;
          main_pc_nxt    = in_pc;
          main_inst_nxt  = in_inst;
        end else begin
          main_valid_nxt = 1'b0;
        end
      end else if (in_xfer) begin
        skid_valid_nxt = 1'b1;
        skid_pc_nxt    = in_pc;
        skid_inst_nxt  = in_inst;
      end
    end
  end

  always_ff @(posedge clk) begin
    main_valid <= main_valid_nxt;
    main_pc    <= main_pc_nxt;
    main_inst  <= main_inst_nxt;
    skid_valid <= skid_valid_nxt;
    skid_pc    <= skid_pc_nxt;
    skid_inst  <= skid_inst_nxt;
    ready_q    <= ~skid_valid_nxt;
    occ_q      <= {1'b0, main_valid_nxt} + {1'b0, skid_valid_nxt};
  end
`else
  assign in_ready = ~main_valid | out_ready;

  always_comb begin
    main_valid_nxt = main_valid;
    main_pc_nxt    = main_pc;
    main_inst_nxt  = main_inst;
    if (rst || flush) begin
      main_valid_nxt = 1'b0;
    end else if (main_free) begin
      main_valid_nxt = in_xfer;
      if (in_xfer) begin
        main_pc_nxt   = in_pc;
        main_inst_nxt = in_inst;
      end
    end
  end

  always_ff @(posedge clk) begin
    main_valid <= main_valid_nxt;
    main_pc    <= main_pc_nxt;
    main_inst  <= main_inst_nxt;
    occ_q      <= {1'b0, main_valid_nxt};
  end
`endif

  // an empty slot must read as an all-zero NOP, never as stale data
  assign out_valid = main_valid;
  assign out_pc    = main_valid ? main_pc : '0;
  assign out_inst  = main_valid ? main_inst : '0;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: vector table, corner sequences and a random run
// compared against a queue-based model of the stage.
module tb_if_id_stage;

`ifdef IF_ID_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam int FULL_OCC = SKID ? 2 : 1;

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_inst, out_pc, out_inst;
  logic [1:0]  occupancy;

  if_id_stage #(.PC_W(32), .INST_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] mq_pc[$];
  logic [31:0] mq_inst[$];
  logic [31:0] out_log[$];

  logic        obs_v, obs_rdy;
  logic [31:0] obs_pc, obs_inst;
  logic [1:0]  obs_occ;

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ordy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einst;
    logic [1:0]  eocc;
    logic        erdy;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'h2000_0000 | pc;
  endfunction

  function automatic vec_t mk(input logic iv, input logic [31:0] pc, input logic ordy,
                              input logic ev, input logic [31:0] epc, input logic [1:0] eocc);
    vec_t v;
    v.iv = iv; v.pc = pc; v.inst = inst_of(pc); v.ordy = ordy;
    v.ev = ev; v.epc = epc; v.einst = ev ? inst_of(epc) : 32'h0;
    v.eocc = eocc; v.erdy = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: drive, compare against the model before the edge, then advance the model.
  task automatic step(input logic r, input logic f, input logic iv, input logic [31:0] pc,
                      input logic [31:0] inst, input logic ordy, output logic acc);
    logic        e_v, e_rdy;
    logic [31:0] e_pc, e_inst;
    @(negedge clk);
    rst = r; flush = f; in_valid = iv; in_pc = pc; in_inst = inst; out_ready = ordy;
    #1;
    e_v    = mq_pc.size() > 0;
    e_pc   = e_v ? mq_pc[0] : 32'h0;
    e_inst = e_v ? mq_inst[0] : 32'h0;
    e_rdy  = SKID ? (mq_pc.size() < 2) : (mq_pc.size() == 0 || ordy);
    chk("out_valid", out_valid, e_v);
    chk("out_pc", out_pc, e_pc);
    chk("out_inst", out_inst, e_inst);
    chk("occupancy", occupancy, mq_pc.size());
    chk("in_ready", in_ready, e_rdy);
    obs_v = out_valid; obs_pc = out_pc; obs_inst = out_inst;
    obs_occ = occupancy; obs_rdy = in_ready;
    if (out_valid && ordy && !r) out_log.push_back(out_pc);
    acc = iv && in_ready;
    @(posedge clk);
    if (r || f) begin
      mq_pc.delete();
      mq_inst.delete();
    end else begin
      if (e_v && ordy) begin
        void'(mq_pc.pop_front());
        void'(mq_inst.pop_front());
      end
      if (iv && e_rdy) begin
        mq_pc.push_back(pc);
        mq_inst.push_back(inst);
      end
    end
  endtask

  task automatic do_reset();
    logic acc;
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, acc);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, acc);
  endtask

  // Drive a list of PCs as a well-behaved source (hold until accepted) with fixed out_ready.
  task automatic run_src(inout logic [31:0] src[$], input int cycles, input logic ordy);
    logic acc;
    for (int i = 0; i < cycles; i++) begin
      if (src.size() > 0) step(1'b0, 1'b0, 1'b1, src[0], inst_of(src[0]), ordy, acc);
      else                step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, ordy, acc);
      if (acc) void'(src.pop_front());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    logic [31:0] src[$];
    logic [31:0] next_pc;
    logic        r, f, iv, ordy;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);

    // reset then stream, bubbles mid-stream
    tbl[0]  = mk(1'b1, 32'h0,        1'b1, 1'b0, 32'h0,  2'd0);
    tbl[1]  = mk(1'b1, 32'h4,        1'b1, 1'b1, 32'h0,  2'd1);
    tbl[2]  = mk(1'b1, 32'h8,        1'b1, 1'b1, 32'h4,  2'd1);
    tbl[3]  = mk(1'b0, 32'hDEAD_BEE0, 1'b1, 1'b1, 32'h8,  2'd1);
    tbl[4]  = mk(1'b0, 32'hDEAD_BEE4, 1'b1, 1'b0, 32'h0,  2'd0);
    tbl[5]  = mk(1'b1, 32'h10,       1'b1, 1'b0, 32'h0,  2'd0);
    tbl[6]  = mk(1'b0, 32'hDEAD_BEE8, 1'b1, 1'b1, 32'h10, 2'd1);
    tbl[7]  = mk(1'b0, 32'hDEAD_BEEC, 1'b1, 1'b0, 32'h0,  2'd0);
    tbl[8]  = mk(1'b0, 32'hDEAD_BEF0, 1'b1, 1'b0, 32'h0,  2'd0);
    tbl[9]  = mk(1'b1, 32'h14,       1'b1, 1'b0, 32'h0,  2'd0);
    tbl[10] = mk(1'b0, 32'hDEAD_BEF4, 1'b1, 1'b1, 32'h14, 2'd1);
    tbl[11] = mk(1'b0, 32'hDEAD_BEF8, 1'b1, 1'b0, 32'h0,  2'd0);

    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, tbl[i].iv, tbl[i].pc, tbl[i].inst, tbl[i].ordy, acc);
      chk($sformatf("tbl%0d_valid", i), obs_v, tbl[i].ev);
      chk($sformatf("tbl%0d_pc", i), obs_pc, tbl[i].epc);
      chk($sformatf("tbl%0d_inst", i), obs_inst, tbl[i].einst);
      chk($sformatf("tbl%0d_occ", i), obs_occ, tbl[i].eocc);
      chk($sformatf("tbl%0d_rdy", i), obs_rdy, tbl[i].erdy);
    end

    // stall, then release: order preserved, nothing lost
    do_reset();
    src = '{32'h100, 32'h104, 32'h108};
    run_src(src, 5, 1'b0);
    chk("stall_occ", obs_occ, FULL_OCC);
    chk("stall_in_ready", obs_rdy, 1'b0);
    chk("stall_held_upstream", src.size(), SKID ? 1 : 2);
    out_log.delete();
    run_src(src, 8, 1'b1);
    chk("release_count", out_log.size(), 3);
    if (out_log.size() == 3) begin
      chk("release_0", out_log[0], 32'h100);
      chk("release_1", out_log[1], 32'h104);
      chk("release_2", out_log[2], 32'h108);
    end

    // flush with a simultaneous input
    do_reset();
    src = '{32'h200, 32'h204};
    run_src(src, 3, 1'b0);
    chk("preflush_occ", obs_occ, FULL_OCC);
    step(1'b0, 1'b1, 1'b1, 32'h208, inst_of(32'h208), 1'b0, acc);
    out_log.delete();
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, acc);
    chk("flush_valid", obs_v, 1'b0);
    chk("flush_pc", obs_pc, 32'h0);
    chk("flush_inst", obs_inst, 32'h0);
    chk("flush_occ", obs_occ, 2'd0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, acc);
    chk("flush_nothing_out", out_log.size(), 0);

    // reset mid-stall
    src = '{32'h300, 32'h304, 32'h308};
    run_src(src, 4, 1'b0);
    chk("prerst_occ", obs_occ, FULL_OCC);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, acc);
    out_log.delete();
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, acc);
    chk("rst_valid", obs_v, 1'b0);
    chk("rst_pc", obs_pc, 32'h0);
    chk("rst_inst", obs_inst, 32'h0);
    chk("rst_occ", obs_occ, 2'd0);
    chk("rst_in_ready", obs_rdy, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, acc);
    chk("rst_nothing_out", out_log.size(), 0);

    // random traffic against the model
    next_pc = 32'h1000;
    for (int i = 0; i < 500; i++) begin
      r    = ($urandom_range(63) == 0);
      f    = ($urandom_range(15) == 0);
      iv   = ($urandom_range(3) != 0);
      ordy = ($urandom_range(2) != 0);
      step(r, f, iv, next_pc, inst_of(next_pc) ^ $urandom(), ordy, acc);
      if (acc && !r && !f) next_pc += 32'd4;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
